pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 61 ++++++
 rtl/pipeline_ctrl_if.sv | 41 ++++
 rtl/pipeline_ctrl_mem_wait_timer.sv | 27 ++
 rtl/pipeline_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2,
    HALT     = 2'd3
  } state_t;

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t PC_SEL_SEQ  = 2'd0;
  localparam pc_sel_t PC_SEL_BR   = 2'd1;
  localparam pc_sel_t PC_SEL_TRAP = 2'd2;
  localparam pc_sel_t PC_SEL_MEPC = 2'd3;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;
  localparam int unsigned TIMER_W             = 8;

  typedef struct packed {
    logic    en_pc;
    logic    en_ifid;
    logic    en_idex;
    logic    en_exmem;
    logic    en_memwb;
    logic    flush_ifid;
    logic    flush_idex;
    logic    flush_exmem;
    logic    flush_memwb;
    pc_sel_t pc_sel;
    logic    trap_we;
    logic    bus_err;
    logic    halted;
  } ctl_t;

  localparam ctl_t CTL_RESET = '{
    en_pc: 1'b0, en_ifid: 1'b0, en_idex: 1'b0, en_exmem: 1'b0, en_memwb: 1'b0,
    flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0, flush_memwb: 1'b0,
    pc_sel: PC_SEL_SEQ, trap_we: 1'b0, bus_err: 1'b0, halted: 1'b0};

  localparam ctl_t CTL_RUN = '{
    en_pc: 1'b1, en_ifid: 1'b1, en_idex: 1'b1, en_exmem: 1'b1, en_memwb: 1'b1,
    flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0, flush_memwb: 1'b0,
    pc_sel: PC_SEL_SEQ, trap_we: 1'b0, bus_err: 1'b0, halted: 1'b0};

  localparam ctl_t CTL_TRAP = '{
    en_pc: 1'b1, en_ifid: 1'b1, en_idex: 1'b1, en_exmem: 1'b1, en_memwb: 1'b1,
    flush_ifid: 1'b1, flush_idex: 1'b1, flush_exmem: 1'b1, flush_memwb: 1'b1,
    pc_sel: PC_SEL_TRAP, trap_we: 1'b1, bus_err: 1'b0, halted: 1'b0};

  localparam ctl_t CTL_FREEZE = '{
    en_pc: 1'b0, en_ifid: 1'b0, en_idex: 1'b0, en_exmem: 1'b0, en_memwb: 1'b1,
    flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0, flush_memwb: 1'b1,
    pc_sel: PC_SEL_SEQ, trap_we: 1'b0, bus_err: 1'b0, halted: 1'b0};

  localparam ctl_t CTL_HALT = '{
    en_pc: 1'b0, en_ifid: 1'b0, en_idex: 1'b0, en_exmem: 1'b0, en_memwb: 1'b0,
    flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0, flush_memwb: 1'b0,
    pc_sel: PC_SEL_SEQ, trap_we: 1'b0, bus_err: 1'b0, halted: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_if.sv
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic        load_use;
  logic        br_taken_EX;
  logic        mem_req_MEM;
  logic        mem_ack;
  logic        exp_MEM;
  logic        mret_MEM;
  logic        halt_req;

  logic        en_PC;
  logic        en_IFID;
  logic        en_IDEX;
  logic        en_EXMEM;
  logic        en_MEMWB;
  logic        flush_IFID;
  logic        flush_IDEX;
  logic        flush_EXMEM;
  logic        flush_MEMWB;
  pc_sel_t     pc_sel;
  logic        trap_we;
  logic        bus_err;
  logic        halted;
  logic [31:0] stall_cycles;

  modport master (
    output load_use, br_taken_EX, mem_req_MEM, mem_ack, exp_MEM, mret_MEM, halt_req,
    input  en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
           flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB,
           pc_sel, trap_we, bus_err, halted, stall_cycles
  );

  modport slave (
    input  load_use, br_taken_EX, mem_req_MEM, mem_ack, exp_MEM, mret_MEM, halt_req,
    output en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
           flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB,
           pc_sel, trap_we, bus_err, halted, stall_cycles
  );

endinterface

// File: rtl/pipeline_ctrl_mem_wait_timer.sv
module mem_wait_timer
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic expired
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= TIMER_W'(1);
    end else if (inc && (count != '1)) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign expired = (count == TIMER_W'(MEM_TIMEOUT));

endmodule

// File: rtl/pipeline_ctrl.sv
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  state_t      state, state_next;
  ctl_t        ctl;
  logic        tmr_load;
  logic        tmr_inc;
  logic        tmr_expired;
  logic [31:0] stall_cnt;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // rst also gates the combinational outputs so nothing pulses while reset is held.
  always_comb begin
    state_next = state;
    ctl        = CTL_RUN;
    tmr_load   = 1'b0;
    tmr_inc    = 1'b0;

    unique case (state)
      RUN: begin
        if (bus.exp_MEM || bus.mret_MEM) begin
          ctl = CTL_TRAP;
          if (!bus.exp_MEM) begin
            ctl.pc_sel  = PC_SEL_MEPC;
            ctl.trap_we = 1'b0;
          end
          state_next = TRAP;
        end else if (bus.mem_req_MEM && !bus.mem_ack) begin
          ctl        = CTL_FREEZE;
          tmr_load   = 1'b1;
          state_next = MEM_WAIT;
        end else if (bus.halt_req) begin
          ctl        = CTL_HALT;
          state_next = HALT;
        end else if (bus.br_taken_EX) begin
          ctl.pc_sel     = PC_SEL_BR;
          ctl.flush_ifid = 1'b1;
          ctl.flush_idex = 1'b1;
        end else if (bus.load_use) begin
          ctl.en_pc      = 1'b0;
          ctl.en_ifid    = 1'b0;
          ctl.flush_idex = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ack) begin
          state_next = RUN;
        end else if (tmr_expired) begin
          ctl         = CTL_TRAP;
          ctl.bus_err = 1'b1;
          state_next  = TRAP;
        end else begin
          ctl     = CTL_FREEZE;
          tmr_inc = 1'b1;
        end
      end
      TRAP: begin
        state_next = RUN;
      end
      HALT: begin
        if (bus.halt_req) begin
          ctl = CTL_HALT;
        end else begin
          state_next = RUN;
        end
      end
    endcase

    if (rst) begin
      state_next = RUN;
      ctl        = CTL_RESET;
      tmr_load   = 1'b0;
      tmr_inc    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!ctl.en_pc && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.en_PC        = ctl.en_pc;
  assign bus.en_IFID      = ctl.en_ifid;
  assign bus.en_IDEX      = ctl.en_idex;
  assign bus.en_EXMEM     = ctl.en_exmem;
  assign bus.en_MEMWB     = ctl.en_memwb;
  assign bus.flush_IFID   = ctl.flush_ifid;
  assign bus.flush_IDEX   = ctl.flush_idex;
  assign bus.flush_EXMEM  = ctl.flush_exmem;
  assign bus.flush_MEMWB  = ctl.flush_memwb;
  assign bus.pc_sel       = ctl.pc_sel;
  assign bus.trap_we      = ctl.trap_we;
  assign bus.bus_err      = ctl.bus_err;
  assign bus.halted       = ctl.halted;
  assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic clk;
  logic rst;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(
    .MEM_TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input vector order: {load_use, br_taken_EX, mem_req_MEM, mem_ack, exp_MEM, mret_MEM, halt_req}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1000000;
  localparam logic [6:0] BR   = 7'b0100000;
  localparam logic [6:0] MR   = 7'b0010000;
  localparam logic [6:0] MA   = 7'b0001000;
  localparam logic [6:0] EX   = 7'b0000100;
  localparam logic [6:0] MT   = 7'b0000010;
  localparam logic [6:0] HR   = 7'b0000001;

  // Control vector: {en PC,IFID,IDEX,EXMEM,MEMWB | flush IFID,IDEX,EXMEM,MEMWB | pc_sel | trap_we, bus_err, halted}
  localparam logic [13:0] C_RST = 14'b00000_0000_00_000;
  localparam logic [13:0] C_RUN = 14'b11111_0000_00_000;
  localparam logic [13:0] C_FRZ = 14'b00001_0001_00_000;
  localparam logic [13:0] C_TRP = 14'b11111_1111_10_100;
  localparam logic [13:0] C_MRT = 14'b11111_1111_11_000;
  localparam logic [13:0] C_BUS = 14'b11111_1111_10_110;
  localparam logic [13:0] C_BR  = 14'b11111_1100_01_000;
  localparam logic [13:0] C_LU  = 14'b00111_0100_00_000;
  localparam logic [13:0] C_HLT = 14'b00000_0000_00_001;

  typedef struct {
    logic [13:0] ctl;
    logic [31:0] stall;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] stall_model = '0;

  task automatic step(input logic r, input logic [6:0] iv, input logic [13:0] ectl,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    {bus.load_use, bus.br_taken_EX, bus.mem_req_MEM, bus.mem_ack,
     bus.exp_MEM, bus.mret_MEM, bus.halt_req} = iv;
    if (r) stall_model = '0;
    e.ctl   = ectl;
    e.stall = stall_model;
    e.name  = nm;
    sb.push_back(e);
    if (!r && !ectl[13]) stall_model = stall_model + 32'd1;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [13:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {bus.en_PC, bus.en_IFID, bus.en_IDEX, bus.en_EXMEM, bus.en_MEMWB,
               bus.flush_IFID, bus.flush_IDEX, bus.flush_EXMEM, bus.flush_MEMWB,
               bus.pc_sel, bus.trap_we, bus.bus_err, bus.halted};
        n_checks++;
        if (act !== e.ctl) begin
          n_fail++;
          $display("FAIL %s ctl: got %b required %b", e.name, act, e.ctl);
        end
        n_checks++;
        if (bus.stall_cycles !== e.stall) begin
          n_fail++;
          $display("FAIL %s stall_cycles: got %0d required %0d", e.name, bus.stall_cycles, e.stall);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b1;
    {bus.load_use, bus.br_taken_EX, bus.mem_req_MEM, bus.mem_ack,
     bus.exp_MEM, bus.mret_MEM, bus.halt_req} = NONE;

    step(1'b1, NONE, C_RST, "reset0");
    step(1'b1, MR | EX | HR, C_RST, "reset1_inputs_masked");
    step(1'b0, NONE, C_RUN, "idle");

    step(1'b0, LU, C_LU, "load_use");
    step(1'b0, NONE, C_RUN, "after_load_use");

    step(1'b0, BR, C_BR, "branch");
    step(1'b0, BR | LU, C_BR, "branch_over_load_use");

    step(1'b0, MR, C_FRZ, "mem_run_freeze");
    step(1'b0, MR, C_FRZ, "mem_wait_1");
    step(1'b0, MR, C_FRZ, "mem_wait_2");
    step(1'b0, MR | MA, C_RUN, "mem_wait_ack");
    step(1'b0, NONE, C_RUN, "after_mem_ack");
    step(1'b0, MR | MA, C_RUN, "mem_ack_no_stall");

    step(1'b0, EX | BR | LU, C_TRP, "exp_over_all");
    step(1'b0, EX, C_RUN, "trap_ignores_exp");
    step(1'b0, NONE, C_RUN, "after_trap");

    step(1'b0, MT, C_MRT, "mret");
    step(1'b0, MT, C_RUN, "trap_ignores_mret");
    step(1'b0, EX | MT, C_TRP, "exp_over_mret");
    step(1'b0, NONE, C_RUN, "trap_after_exp");
    step(1'b0, EX | MR, C_TRP, "exp_over_mem");
    step(1'b0, NONE, C_RUN, "trap_after_exp_mem");

    step(1'b0, MR | HR, C_FRZ, "mem_over_halt");
    step(1'b0, MR | EX, C_FRZ, "mw1_ignores_exp");
    step(1'b0, MR | MT | BR, C_FRZ, "mw2_ignores_mret_br");
    step(1'b0, MR | HR, C_FRZ, "mw3_ignores_halt");
    step(1'b0, MR, C_BUS, "mw4_timeout");
    step(1'b0, MR, C_RUN, "trap_after_timeout");
    step(1'b0, NONE, C_RUN, "run_after_timeout");

    step(1'b0, HR | BR, C_HLT, "halt_over_branch");
    step(1'b0, HR | EX, C_HLT, "halt_hold");
    step(1'b0, NONE, C_RUN, "halt_exit");
    step(1'b0, NONE, C_RUN, "after_halt");

    step(1'b0, MR, C_FRZ, "mem_before_rst");
    step(1'b0, MR, C_FRZ, "mw_before_rst");
    step(1'b1, MR, C_RST, "rst_mid_mem_wait");
    step(1'b1, MR, C_RST, "rst_mid_mem_wait_2");
    step(1'b0, NONE, C_RUN, "run_after_mw_rst");

    step(1'b0, HR, C_HLT, "halt_cycle1");
    step(1'b0, HR, C_HLT, "halt_cycle2");
    step(1'b1, HR, C_RST, "halt_cycle3_rst");
    step(1'b1, HR, C_RST, "halt_cycle4_rst");
    step(1'b1, HR, C_RST, "halt_cycle5_rst");
    step(1'b0, NONE, C_RUN, "run_after_halt_rst");
    step(1'b0, LU, C_LU, "load_use_after_rst");
    step(1'b0, NONE, C_RUN, "final");

    repeat (3) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
